// File: rtl/lvds_loop_pkg.sv
// Constants and types shared by the LVDS loopback pattern generator and the
// far-end stride checker, so both ends agree on the stream format.
package lvds_loop_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      RUN      = 2'd2
   } state_e;

   localparam int         DEFAULT_WIDTH     = 8;
   localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;
   localparam int         DEFAULT_STRIDE    = 1;

   // Counter width for a length n, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lvds_pattern_gen.sv
// Transmit-side LVDS loopback pattern source: sync preamble, then a
// stride-incrementing word stream with optional burst length and error injection.
module lvds_pattern_gen
   import lvds_loop_pkg::*;
#(
   parameter int               WIDTH        = DEFAULT_WIDTH,
   parameter int               STRIDE       = DEFAULT_STRIDE,
   parameter logic [WIDTH-1:0] SEED         = WIDTH'(1),
   parameter logic [WIDTH-1:0] SYNC_WORD    = WIDTH'(DEFAULT_SYNC_WORD),
   parameter int               PREAMBLE_LEN = 16,
   parameter int               BURST_LEN    = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             inject_err,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             sync,
   output logic             busy,
   output logic [15:0]      word_count
);

   localparam int               PCW        = cnt_width(PREAMBLE_LEN);
   localparam int               BCW        = cnt_width(BURST_LEN);
   localparam logic [PCW-1:0]   PRE_LAST   = PCW'(PREAMBLE_LEN - 1);
   localparam logic [BCW-1:0]   BURST_LAST = BCW'(BURST_LEN - 1);
   localparam logic [WIDTH-1:0] STEP       = WIDTH'(STRIDE);

   state_e           state_q, state_d;
   logic [PCW-1:0]   pre_cnt_q, pre_cnt_d;
   logic [BCW-1:0]   burst_cnt_q, burst_cnt_d;
   logic [WIDTH-1:0] seq_q, seq_d;
   logic [15:0]      wc_q, wc_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             sync_q, sync_d;
   logic             busy_q, busy_d;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // stop outranks both start and the burst-end transition.
   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      state_d = state_q;
      case (state_q)
         IDLE:     if (start && !stop) state_d = PREAMBLE;
         PREAMBLE: if (stop) state_d = IDLE;
                   else if (pre_cnt_q == PRE_LAST) state_d = RUN;
         RUN:      if (stop) state_d = IDLE;
                   else if (BURST_LEN != 0 && burst_cnt_q == BURST_LAST) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Counters index the word that is on data_out after the edge.
   always_comb begin
      pre_cnt_d   = pre_cnt_q;
      burst_cnt_d = burst_cnt_q;
      seq_d       = seq_q;
      wc_d        = wc_q;
      if (state_q == IDLE && state_d == PREAMBLE) begin
         pre_cnt_d   = '0;
         burst_cnt_d = '0;
         seq_d       = SEED;
         wc_d        = '0;
      end
      if (state_q == PREAMBLE && state_d == PREAMBLE) pre_cnt_d = pre_cnt_q + 1'b1;
      if (state_d == RUN) begin
         seq_d       = seq_q + STEP;
         wc_d        = (wc_q == 16'hFFFF) ? wc_q : wc_q + 16'd1;
         burst_cnt_d = (state_q == RUN) ? burst_cnt_q + 1'b1 : '0;
      end
   end

   // Output decode from the next state, so outputs change on the same edge as state.
   always_comb begin
      data_d  = '0;
      valid_d = 1'b0;
      sync_d  = 1'b0;
      busy_d  = 1'b0;
      case (state_d)
         PREAMBLE: begin
            data_d = SYNC_WORD;
            sync_d = 1'b1;
            busy_d = 1'b1;
         end
         RUN: begin
            // Flipping bit0 only on the emitted word lets seq resync next word.
            data_d  = seq_q ^ WIDTH'(inject_err && state_q == RUN);
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q   <= '0;
         burst_cnt_q <= '0;
         seq_q       <= SEED;
         wc_q        <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         sync_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         pre_cnt_q   <= pre_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         seq_q       <= seq_d;
         wc_q        <= wc_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         sync_q      <= sync_d;
         busy_q      <= busy_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign sync       = sync_q;
   assign busy       = busy_q;
   assign word_count = wc_q;

endmodule

// File: tb/tb_lvds_pattern_gen.sv
// Directed bench for lvds_pattern_gen: default instance plus a finite-burst
// instance (STRIDE=3, SEED=FA, BURST_LEN=4), with a simple far-end stride monitor.
module tb_lvds_pattern_gen;

   typedef struct {
      logic        start, stop, inj;
      logic [7:0]  data;
      logic        valid, sync, busy;
      logic [15:0] wc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, stop = 1'b0, inject_err = 1'b0;
   logic [7:0]  data_out;
   logic        data_valid, sync, busy;
   logic [15:0] word_count;
   logic        start_b = 1'b0, stop_b = 1'b0, inject_b = 1'b0;
   logic [7:0]  data_out_b;
   logic        data_valid_b, sync_b, busy_b;
   logic [15:0] word_count_b;

   int pass_cnt = 0;
   int total_cnt = 0;
   int stride_errs = 0;
   logic [7:0] mon_prev = 8'h00;
   logic       mon_prev_ok = 1'b0;

   always #5 clk = ~clk;

   lvds_pattern_gen dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .inject_err(inject_err),
      .data_out(data_out), .data_valid(data_valid), .sync(sync), .busy(busy),
      .word_count(word_count)
   );

   lvds_pattern_gen #(.STRIDE(3), .SEED(8'hFA), .BURST_LEN(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .inject_err(inject_b),
      .data_out(data_out_b), .data_valid(data_valid_b), .sync(sync_b), .busy(busy_b),
      .word_count(word_count_b)
   );

   // Far-end stride checker model (stride 1): counts words that break the sequence.
   always @(negedge clk) begin
      if (data_valid) begin
         if (mon_prev_ok && data_out != mon_prev + 8'd1) stride_errs <= stride_errs + 1;
         mon_prev    <= data_out;
         mon_prev_ok <= 1'b1;
      end else begin
         mon_prev_ok <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic s, input logic p, input logic i, input logic sb);
      @(negedge clk);
      start = s; stop = p; inject_err = i; start_b = sb;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [26:0] tup_a();
      return {data_out, data_valid, sync, busy, word_count};
   endfunction

   function automatic logic [26:0] tup_b();
      return {data_out_b, data_valid_b, sync_b, busy_b, word_count_b};
   endfunction

   function automatic logic [26:0] exp_t(input logic [7:0] d, input logic v, input logic y,
                                         input logic b, input logic [15:0] w);
      return {d, v, y, b, w};
   endfunction

   function automatic vec_t mk(input logic s, input logic p, input logic i, input logic [7:0] d,
                               input logic v, input logic y, input logic b, input logic [15:0] w);
      vec_t r;
      r.start = s; r.stop = p; r.inj = i; r.data = d;
      r.valid = v; r.sync = y; r.busy = b; r.wc = w;
      return r;
   endfunction

   initial begin
      vec_t vecs[$];
      logic [7:0] burst_exp [4];
      int errs0;
      burst_exp = '{8'hFA, 8'hFD, 8'h00, 8'h03};

      // Preamble (inject ignored there), RUN 01..10, inject, stop, start+stop.
      vecs.push_back(mk(1, 0, 0, 8'hA5, 0, 1, 1, 16'd0));
      for (int i = 1; i < 16; i++) vecs.push_back(mk(0, 0, i == 5, 8'hA5, 0, 1, 1, 16'd0));
      for (int w = 1; w <= 16; w++) vecs.push_back(mk(0, 0, 0, 8'(w), 1, 0, 1, 16'(w)));
      vecs.push_back(mk(0, 0, 1, 8'h10, 1, 0, 1, 16'd17));
      vecs.push_back(mk(0, 0, 0, 8'h12, 1, 0, 1, 16'd18));
      vecs.push_back(mk(0, 0, 0, 8'h13, 1, 0, 1, 16'd19));
      vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 16'd19));
      vecs.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0, 16'd19));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 16'd19));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 16'd19));

      @(negedge clk);
      @(negedge clk);
      check("reset_a", tup_a(), exp_t(8'h00, 0, 0, 0, 16'd0));
      check("reset_b", tup_b(), exp_t(8'h00, 0, 0, 0, 16'd0));
      rst_n = 1'b1;

      errs0 = stride_errs;
      for (int k = 0; k < vecs.size(); k++) begin
         drive(vecs[k].start, vecs[k].stop, vecs[k].inj, 1'b0);
         check($sformatf("vec%0d", k), tup_a(),
               exp_t(vecs[k].data, vecs[k].valid, vecs[k].sync, vecs[k].busy, vecs[k].wc));
      end
      @(negedge clk);
      check("inject_stride_errs", 27'(stride_errs - errs0), 27'd2);

      // Restart from SEED with a continuous run through the FF->00 wrap.
      drive(1, 0, 0, 0);
      check("cont_pre0", tup_a(), exp_t(8'hA5, 0, 1, 1, 16'd0));
      for (int i = 1; i < 16; i++) begin
         drive(0, 0, 0, 0);
         check($sformatf("cont_pre%0d", i), tup_a(), exp_t(8'hA5, 0, 1, 1, 16'd0));
      end
      errs0 = stride_errs;
      for (int i = 0; i < 300; i++) begin
         drive(0, 0, 0, 0);
         check($sformatf("cont_word%0d", i), tup_a(), exp_t(8'(1 + i), 1, 0, 1, 16'(i + 1)));
      end
      @(negedge clk);
      check("cont_stride_errs", 27'(stride_errs - errs0), 27'd0);

      // Asynchronous reset between edges in the middle of the preamble.
      drive(0, 1, 0, 0);
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1 check("async_rst_a", tup_a(), exp_t(8'h00, 0, 0, 0, 16'd0));
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 0, 0);
      check("rst_pre0", tup_a(), exp_t(8'hA5, 0, 1, 1, 16'd0));
      for (int i = 1; i < 16; i++) begin
         drive(0, 0, 0, 0);
         check($sformatf("rst_pre%0d", i), tup_a(), exp_t(8'hA5, 0, 1, 1, 16'd0));
      end
      drive(0, 0, 0, 0);
      check("rst_first_word", tup_a(), exp_t(8'h01, 1, 0, 1, 16'd1));

      // Finite burst with stride 3; a second start mid-preamble is ignored.
      drive(0, 1, 0, 1);
      check("burst_pre0", tup_b(), exp_t(8'hA5, 0, 1, 1, 16'd0));
      for (int i = 1; i < 16; i++) begin
         drive(0, 0, 0, i == 8);
         check($sformatf("burst_pre%0d", i), tup_b(), exp_t(8'hA5, 0, 1, 1, 16'd0));
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0);
         check($sformatf("burst_word%0d", i), tup_b(), exp_t(burst_exp[i], 1, 0, 1, 16'(i + 1)));
      end
      drive(0, 0, 0, 0);
      check("burst_end", tup_b(), exp_t(8'h00, 0, 0, 0, 16'd4));
      drive(0, 0, 0, 0);
      check("burst_idle_hold", tup_b(), exp_t(8'h00, 0, 0, 0, 16'd4));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
